btn_deb_counter: RTL and testbench
==================================

Name: btn_deb_counter

Overview:
- Upstream stage of the two-digit hex display multiplexer.
- Produces the 8-bit value that the multiplexer shows as two hex nibbles (low nibble on digit 0, high nibble on digit 1).
- Three board push-buttons are synchronised, debounced and edge-detected, then drive an 8-bit up/down counter. The counter can also be loaded from the slide switches.

Parameters:
- DEB_CYCLES, 1000000: clock cycles a synchronised button level must stay stable before the debounced level follows it (10 ms at 100 MHz). Legal range is 2 to 2^24-1.
- SIM_FAST, 0: reserved. It has no functional effect. The bench overrides DEB_CYCLES instead.

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- btn_inc, in, 1: raw increment button, asynchronous and bouncing.
- btn_dec, in, 1: raw decrement button, asynchronous and bouncing.
- btn_load, in, 1: raw load button, asynchronous and bouncing.
- sw, in, 8: load value. Sampled directly; it is treated as quasi-static.
- count, out, 8: current value, fed to the display multiplexer's sw input.
- changed, out, 1: one-cycle pulse in the cycle after count takes a new value.

Behaviour:
- Reset (rst=1 at a clk edge):
  - count=8'h00 and changed=0.
  - Synchroniser flops, debounced levels and debounce counters all clear to 0.
  - Reset overrides every other event in the same cycle.
  - A button held through reset release is debounced fresh from level 0, so it yields exactly one press after DEB_CYCLES.
- Synchroniser: two flops per button. Call the second-stage output s.
- Debouncer, per button, with 24-bit counter dc and debounced level d:
  - If s==d: dc<=0.
  - Else if dc==DEB_CYCLES-1: d<=s and dc<=0.
  - Else: dc<=dc+1.
  - Any glitch back to s==d restarts the count.
- Edge detect: p = d & ~d_prev (d_prev is a registered copy of d). p is high for exactly one cycle per debounced rising edge. Release events generate nothing.
- Latency from a clean raw rising edge, held:
  - 2 cycles of synchroniser.
  - DEB_CYCLES cycles for d to rise.
  - 1 cycle for p.
  - count updates on the edge at which p is high, i.e. count changes DEB_CYCLES+3 edges after the raw edge.
  - changed is high for the following cycle.
- Update priority, evaluated per cycle from the p_load, p_inc, p_dec pulses:
  - p_load=1: count<=sw (inc/dec are ignored that cycle).
  - p_inc=1 and p_dec=1: count unchanged, changed stays 0.
  - p_inc only: count<=count+1, modulo 256 (8'hFF -> 8'h00).
  - p_dec only: count<=count-1, modulo 256 (8'h00 -> 8'hFF).
  - changed<=1 only when count is written with a value different from its current value. Loading an equal value gives changed=0.
- Arithmetic is 8-bit unsigned with no saturation.
- No other state. Outputs are registered and glitch-free.

Test Plan (DEB_CYCLES=4):
- Reset: assert rst 3 cycles with all buttons 1 -> count=00 and changed=0 throughout reset. Keeping btn_inc held after release -> exactly one increment to 01 at edge DEB_CYCLES+3 after release.
- Clean press: from count=00, a btn_inc pulse of 10 cycles -> count=01 exactly 7 edges after the raw edge, and changed=1 for one cycle. Release produces no change.
- Bounce rejection: btn_inc toggling every 2 cycles for 20 cycles, then held high -> no change during the bounce, then a single increment.
- Wrap-around:
  - Load sw=8'hFF via btn_load, press btn_inc -> count=00.
  - Press btn_dec -> count=FF.
  - changed pulses each time.
- Simultaneous and priority events:
  - btn_inc and btn_dec raised on the same cycle, with count=0x42 -> count stays 42 and changed=0.
  - All three raised together with sw=0x5A -> count=5A.
- Reset mid-debounce: press btn_dec at count=10 and assert rst when dc=2 -> count=00. The debounce restarts after rst drops, and a still-held button then yields count=FF.

Source files
------------

// File: rtl/btn_deb_counter.sv
// Debounced push-button up/down/load counter feeding the two-digit hex display.
// Latency: raw press to count update is DEB_CYCLES+3 clocks; there is no backpressure.
module btn_deb_counter #(
  parameter int DEB_CYCLES = 1000000,
  parameter int SIM_FAST   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_load,
  input  logic [7:0] sw,
  output logic [7:0] count,
  output logic       changed
);

  // SIM_FAST is reserved and folds to zero here.
  localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1 + 0 * SIM_FAST);

  localparam int INC  = 0;
  localparam int DEC  = 1;
  localparam int LOAD = 2;

  logic [2:0]  raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  deb;
  logic [2:0]  deb_prev;
  logic [23:0] dc [3];
  logic [2:0]  pulse;
  logic [7:0]  count_nxt;

  assign raw   = {btn_load, btn_dec, btn_inc};
  assign pulse = deb & ~deb_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 3; i++) dc[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      // A level must hold for DEB_CYCLES consecutive cycles; any glitch restarts it.
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          dc[i]  <= '0;
        end else begin
          dc[i] <= dc[i] + 24'd1;
        end
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (pulse[LOAD]) begin
      count_nxt = sw;
    end else if (pulse[INC] && !pulse[DEC]) begin
      count_nxt = count + 8'd1;
    end else if (pulse[DEC] && !pulse[INC]) begin
      count_nxt = count - 8'd1;
    end
  end

  // Loading an equal value leaves changed low.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= 8'h00;
      changed <= 1'b0;
    end else begin
      count   <= count_nxt;
      changed <= (count_nxt != count);
    end
  end

endmodule

// File: tb/tb_btn_deb_counter.sv
// Directed bench for btn_deb_counter with DEB_CYCLES=4 (update lands 7 edges after a raw press).
module tb_btn_deb_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc;
  logic       btn_dec;
  logic       btn_load;
  logic [7:0] sw;
  logic [7:0] count;
  logic       changed;

  int n_checks = 0;
  int n_pass   = 0;

  btn_deb_counter #(.DEB_CYCLES(4), .SIM_FAST(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .btn_load (btn_load),
    .sw       (sw),
    .count    (count),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called right after a raw press is applied: count holds for 6 edges,
  // takes the new value on edge 7 with changed high, changed drops on edge 8.
  task automatic wait_update(input string tag, input logic [7:0] old_v, input logic [7:0] new_v);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check({tag, "_hold"}, count, old_v);
    end
    tick();
    check({tag, "_count"}, count, new_v);
    check({tag, "_chg1"}, {7'd0, changed}, 8'd1);
    tick();
    check({tag, "_chg0"}, {7'd0, changed}, 8'd0);
  endtask

  task automatic idle(input string tag, input int n, input logic [7:0] exp);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_count"}, count, exp);
      check({tag, "_chg"}, {7'd0, changed}, 8'd0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    btn_load = 1'b1;
    sw       = 8'h00;

    // Reset with every button held
    idle("reset", 3, 8'h00);
    rst      = 1'b0;
    btn_dec  = 1'b0;
    btn_load = 1'b0;
    wait_update("rst_hold", 8'h00, 8'h01);
    btn_inc = 1'b0;
    idle("rst_rel", 10, 8'h01);

    // Clean 10-cycle press from zero
    rst = 1'b1;
    tick();
    check("rst2_count", count, 8'h00);
    rst = 1'b0;
    tick();
    btn_inc = 1'b1;
    wait_update("clean", 8'h00, 8'h01);
    idle("clean_held", 2, 8'h01);
    btn_inc = 1'b0;
    idle("clean_rel", 12, 8'h01);

    // Bounce: 2 high, 2 low, five times, then held
    for (int k = 0; k < 20; k++) begin
      btn_inc = ((k % 4) < 2) ? 1'b1 : 1'b0;
      tick();
      check("bounce_count", count, 8'h01);
      check("bounce_chg", {7'd0, changed}, 8'd0);
    end
    btn_inc = 1'b1;
    wait_update("bounce", 8'h01, 8'h02);
    btn_inc = 1'b0;
    idle("bounce_rel", 8, 8'h02);

    // Wrap-around in both directions
    sw = 8'hFF;
    btn_load = 1'b1;
    wait_update("load_ff", 8'h02, 8'hFF);
    btn_load = 1'b0;
    idle("load_ff_rel", 8, 8'hFF);
    btn_inc = 1'b1;
    wait_update("wrap_up", 8'hFF, 8'h00);
    btn_inc = 1'b0;
    idle("wrap_up_rel", 8, 8'h00);
    btn_dec = 1'b1;
    wait_update("wrap_dn", 8'h00, 8'hFF);
    btn_dec = 1'b0;
    idle("wrap_dn_rel", 8, 8'hFF);

    // inc and dec together cancel
    sw = 8'h42;
    btn_load = 1'b1;
    wait_update("load_42", 8'hFF, 8'h42);
    btn_load = 1'b0;
    idle("load_42_rel", 8, 8'h42);
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    idle("inc_dec", 10, 8'h42);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    idle("inc_dec_rel", 8, 8'h42);

    // Load wins over inc/dec
    sw = 8'h5A;
    btn_inc  = 1'b1;
    btn_dec  = 1'b1;
    btn_load = 1'b1;
    wait_update("all3", 8'h42, 8'h5A);
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    btn_load = 1'b0;
    idle("all3_rel", 8, 8'h5A);

    // Loading the current value does not pulse changed
    btn_load = 1'b1;
    idle("load_same", 10, 8'h5A);
    btn_load = 1'b0;
    idle("load_same_rel", 8, 8'h5A);

    // Reset mid-debounce, button still held afterwards
    sw = 8'h10;
    btn_load = 1'b1;
    wait_update("load_10", 8'h5A, 8'h10);
    btn_load = 1'b0;
    idle("load_10_rel", 8, 8'h10);
    btn_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_deb_hold", count, 8'h10);
    end
    rst = 1'b1;
    tick();
    check("mid_rst_count", count, 8'h00);
    check("mid_rst_chg", {7'd0, changed}, 8'd0);
    rst = 1'b0;
    wait_update("post_rst", 8'h00, 8'hFF);
    btn_dec = 1'b0;
    idle("post_rst_rel", 8, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
